// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the instruction-fetch blocks.
//   MIPS_NOP     - all-zero NOP encoding
//   PC_W_DEF     - default PC / instruction-memory word-address width
//   INSTR_W_DEF  - default instruction width
//   entry_w()    - width of one prefetch-buffer entry
// Entry layout, from MSB to LSB: {instr[INSTR_W-1:0], pc_plus1[PC_W-1:0]}.
package mips_pkg;

  localparam int PC_W_DEF    = 10;
  localparam int INSTR_W_DEF = 32;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  // pc_plus1 sits in the low bits and the instruction sits above it.
  function automatic int entry_w(input int pc_w, input int instr_w);
    return pc_w + instr_w;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO that holds the fetch queue's entries.
// Parameters: DEPTH (power of two, 2..16), ENTRY_W (entry width in bits).
// Ports:
//   clk, rst  - clock; synchronous active-high reset of the control state
//   flush     - empties the FIFO; overrides push and pop
//   push, din - write din at the tail (accepted when not full, or when full and popping)
//   pop       - drop the head (ignored when empty)
//   dout      - head entry, all zero when empty
//   full, empty, level - occupancy status
module fetch_fifo #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 42
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [ENTRY_W-1:0]         din,
  input  logic                       pop,
  output logic [ENTRY_W-1:0]         dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]      count_q, count_d;
  logic               do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == LW'(DEPTH));
  assign level = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // The pointers wrap naturally because DEPTH is a power of two.
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_d = count_q + LW'(1);
      else if (do_pop && !do_push) count_d = count_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // The storage is not reset: dout is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage with a decoupling prefetch buffer.
// It holds the fetch PC and reads instruction memory every cycle the buffer
// has room. It queues {instr, PC+1} pairs for decode.
// Optional feature: defining the macro FETCH_NOP_SKIP_EN drops all-zero (NOP)
// instruction words instead of queueing them. The fetch PC still advances.
// Parameters: PC_W, INSTR_W, DEPTH (power of two, 2..16).
// Ports:
//   clk, rst        - clock; synchronous active-high reset
//   init_pc         - fetch PC loaded on reset
//   imem_addr       - instruction-memory read address (the fetch PC)
//   imem_rdata      - asynchronous read data for imem_addr
//   redirect_valid  - taken branch/jump: flush the buffer and reload the PC
//   redirect_pc     - new fetch PC
//   halt            - level-sensitive fetch stop; the buffer keeps draining
//   out_valid/out_ready/out_instr/out_pc - head handshake towards decode
//   level           - current buffer occupancy
module fetch_queue
  import mips_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_W-1:0]        init_pc,
  output logic [PC_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]     imem_rdata,
  input  logic                   redirect_valid,
  input  logic [PC_W-1:0]        redirect_pc,
  input  logic                   halt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [PC_W-1:0]        out_pc,
  output logic [$clog2(DEPTH):0] level
);

  localparam int EW = entry_w(PC_W, INSTR_W);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] pc_plus1;
  logic [EW-1:0]   head;
  logic            fifo_full, fifo_empty;
  logic            pop, fetch, push_fifo;

  assign pc_plus1  = fetch_pc_q + PC_W'(1);   // modulo 2^PC_W
  assign imem_addr = fetch_pc_q;

  assign out_valid = ~fifo_empty;
  assign out_instr = head[EW-1:PC_W];
  assign out_pc    = head[PC_W-1:0];

  assign pop = out_valid & out_ready;

  // A fetch consumes the word at fetch_pc and advances the PC. A full buffer
  // still fetches when the head leaves in the same cycle.
  assign fetch = ~halt & ~redirect_valid & (~fifo_full | pop);

`ifdef FETCH_NOP_SKIP_EN
  // A NOP is consumed (the PC advances) but never enters the buffer.
  assign push_fifo = fetch & (imem_rdata != INSTR_W'(MIPS_NOP));
`else
  assign push_fifo = fetch;
`endif

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) fetch_pc_d = redirect_pc;
    else if (fetch)     fetch_pc_d = pc_plus1;
  end

  always_ff @(posedge clk) begin
    if (rst) fetch_pc_q <= init_pc;
    else     fetch_pc_q <= fetch_pc_d;
  end

  // A redirect flushes the buffer. The head shown in that cycle is discarded
  // whatever out_ready is, so decode must kill it.
  fetch_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push_fifo),
    .din   ({imem_rdata, pc_plus1}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

endmodule
